regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_pick.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: FSM state encoding
// and default register-file geometry.
package regfile_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } wb_state_e;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the lowest requesting index above ptr,
// wrapping to the lowest requesting index overall.
module regfile_wb_arbiter_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] grant
);

  logic [N-1:0] above;
  logic [N-1:0] masked;
  logic [N-1:0] low_masked;
  logic [N-1:0] low_all;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_above
      assign above[gi] = (3'(gi) > {1'b0, ptr});
    end
  endgenerate

  // Two's-complement trick isolates the least significant set bit.
  always_comb begin
    masked     = req & above;
    low_masked = masked & (~masked + N'(1));
    low_all    = req & (~req + N'(1));
    grant      = (|masked) ? low_masked : low_all;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin selects one of NREQ write requesters per cycle,
// registers it onto the register-file write port and exposes bypass hits.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int DROP_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              hold,
  output logic              wr_enb,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [1:0]        grant_id,
  input  logic [AW-1:0]     rd_addr_1,
  input  logic [AW-1:0]     rd_addr_2,
  output logic              byp_hit_1,
  output logic              byp_hit_2,
  output logic [DW-1:0]     byp_data
);

  wb_state_e       state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic            wr_enb_q, wr_enb_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [1:0]      grant_id_q, grant_id_d;

  logic [NREQ-1:0] pick;
  logic            accept;
  logic            drop;
  logic [1:0]      win_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  regfile_wb_arbiter_rr_pick #(.N(NREQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (last_grant_q),
    .grant (pick)
  );

  // Grant depends only on valid, pointer, hold and reset -- never on addr/data.
  always_comb begin
    req_ready = (hold || !rst_n) ? '0 : pick;
    accept    = |req_ready;
    win_idx   = '0;
    win_addr  = '0;
    win_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        win_idx  = 2'(i);
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
    drop         = (DROP_R0 != 0) && (win_addr == '0);
    wr_enb_d     = accept && !drop;
    wr_addr_d    = accept ? win_addr : wr_addr_q;
    wr_data_d    = accept ? win_data : wr_data_q;
    grant_id_d   = accept ? win_idx  : grant_id_q;
    last_grant_d = accept ? win_idx  : last_grant_q;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (hold) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: state_d = ST_IDLE;
        default: state_d = accept ? ST_ISSUE : ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'(NREQ - 1);
      wr_enb_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_enb_q     <= wr_enb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign wr_enb    = wr_enb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;
  assign byp_hit_1 = wr_enb_q && (wr_addr_q == rd_addr_1);
  assign byp_hit_2 = wr_enb_q && (wr_addr_q == rd_addr_2);
  assign byp_data  = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, round-robin order, r0 drop,
// hold, single requester, bypass and asynchronous reset mid-write.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        hold;
  logic        wr_enb;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  grant_id;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic        byp_hit_1;
  logic        byp_hit_2;
  logic [31:0] byp_data;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .DROP_R0(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .hold      (hold),
    .wr_enb    (wr_enb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .byp_hit_1 (byp_hit_1),
    .byp_hit_2 (byp_hit_2),
    .byp_data  (byp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] exp_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [4:0] exp_addr  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
  logic [1:0] exp_gid   [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h102, 32'h101, 32'h100};
    rd_addr_1 = 5'd0;
    rd_addr_2 = 5'd0;

    // Reset with all requesters valid
    @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'b000);
    check("rst_wr_enb", 32'(wr_enb), 32'd0);
    check("rst_byp_hit1", 32'(byp_hit_1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_ready", 32'(req_ready), 32'b001);

    // Continuous round-robin over three requesters
    for (int c = 0; c < 6; c++) begin
      check("rr_ready", 32'(req_ready), 32'(exp_ready[c]));
      if (c > 0) begin
        check("rr_wr_enb", 32'(wr_enb), 32'd1);
        check("rr_wr_addr", 32'(wr_addr), 32'(exp_addr[c-1]));
        check("rr_grant_id", 32'(grant_id), 32'(exp_gid[c-1]));
      end
      next_cycle();
      #1;
    end
    check("rr_last_enb", 32'(wr_enb), 32'd1);
    check("rr_last_addr", 32'(wr_addr), 32'd3);
    check("rr_last_data", wr_data, 32'h102);

    // Requester 1 writes r0: accepted but never issued
    req_valid = 3'b010;
    req_addr  = {5'd3, 5'd0, 5'd1};
    req_data  = {32'h102, 32'd9, 32'h100};
    #1;
    check("r0_ready", 32'(req_ready), 32'b010);
    next_cycle();
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h102, 32'h101, 32'h100};
    #1;
    check("r0_wr_enb", 32'(wr_enb), 32'd0);
    check("r0_ptr_ready", 32'(req_ready), 32'b100);

    // Hold for three cycles with a write already registered
    next_cycle();
    hold = 1'b1;
    #1;
    check("hold0_ready", 32'(req_ready), 32'b000);
    check("hold0_wr_enb", 32'(wr_enb), 32'd1);
    check("hold0_wr_addr", 32'(wr_addr), 32'd3);
    next_cycle();
    #1;
    check("hold1_ready", 32'(req_ready), 32'b000);
    check("hold1_wr_enb", 32'(wr_enb), 32'd0);
    next_cycle();
    #1;
    check("hold2_ready", 32'(req_ready), 32'b000);
    next_cycle();
    hold = 1'b0;
    #1;
    check("resume_ready", 32'(req_ready), 32'b001);

    // Single requester 2, then bypass snoop
    req_valid = 3'b100;
    req_addr  = {5'd5, 5'd2, 5'd1};
    req_data  = {32'hFFFF_FFFD, 32'h101, 32'h100};
    #1;
    check("single_ready", 32'(req_ready), 32'b100);
    next_cycle();
    rd_addr_1 = 5'd5;
    rd_addr_2 = 5'd4;
    #1;
    check("byp_hit_1", 32'(byp_hit_1), 32'd1);
    check("byp_hit_2", 32'(byp_hit_2), 32'd0);
    check("byp_data", byp_data, 32'hFFFF_FFFD);
    check("byp_grant_id", 32'(grant_id), 32'd2);
    check("single_again", 32'(req_ready), 32'b100);

    // Asynchronous reset while a write is on the port
    next_cycle();
    #1;
    check("pre_rst_enb", 32'(wr_enb), 32'd1);
    req_valid = 3'b000;
    rst_n     = 1'b0;
    rd_addr_1 = 5'd0;
    #1;
    check("arst_wr_enb", 32'(wr_enb), 32'd0);
    check("arst_wr_data", wr_data, 32'd0);
    check("arst_byp_hit1", 32'(byp_hit_1), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("rel_wr_enb", 32'(wr_enb), 32'd0);
    next_cycle();
    #1;
    check("rel2_wr_enb", 32'(wr_enb), 32'd0);
    req_valid = 3'b010;
    #1;
    check("rel_ready", 32'(req_ready), 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
